// File: rtl/isa_mon_pkg.sv
// rtl/isa_mon_pkg.sv - shared status encoding, tohost address and field widths for isa_result_monitor
package isa_mon_pkg;

   localparam logic [11:0] TOHOST_ADDR = 12'h51e;
   localparam int          STATUS_W    = 3;
   localparam int          CODE_W      = 31;

   typedef enum logic [STATUS_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_PASS    = 3'd2,
      ST_FAIL    = 3'd3,
      ST_TIMEOUT = 3'd4
   } status_e;

   function automatic logic is_terminal(input status_e s);
      return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
   endfunction

endpackage

// File: rtl/isa_mon_channel.sv
// rtl/isa_mon_channel.sv - one core's tohost result FSM with fail_code and finish_cycle capture
// Optional: ISA_MON_FINISH_CYCLE_EN adds the finish_cycle register and its cycles input.
import isa_mon_pkg::*;

module isa_mon_channel #(
   parameter logic [11:0] CSR_ADDR = TOHOST_ADDR,
   parameter int          CNT_W    = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              timeout_hit,
   input  logic              csr_we,
   input  logic [11:0]       csr_addr,
   input  logic [31:0]       csr_wdata,
`ifdef ISA_MON_FINISH_CYCLE_EN
   input  logic [CNT_W-1:0]  cycles,
`endif
   output status_e           status,
   output status_e           status_nxt,
   output logic [CODE_W-1:0] fail_code,
   output logic [CNT_W-1:0]  finish_cycle
);

   logic valid_wr;
   logic entering;

   // Writes with bit0 clear are ordinary tohost traffic, not a test verdict.
   assign valid_wr = csr_we && (csr_addr == CSR_ADDR) && csr_wdata[0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) status <= ST_IDLE;
      else      status <= status_nxt;
   end

   always_comb begin
      status_nxt = status;
      if (start) begin
         status_nxt = ST_RUN;
      end else if (status == ST_RUN) begin
         if (valid_wr)
            status_nxt = (csr_wdata[31:1] == '0) ? ST_PASS : ST_FAIL;
         else if (timeout_hit)
            status_nxt = ST_TIMEOUT;
      end
   end

   assign entering = (status == ST_RUN) && !start && is_terminal(status_nxt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         fail_code <= '0;
      else if (start)
         fail_code <= '0;
      else if (entering && status_nxt == ST_FAIL)
         fail_code <= csr_wdata[31:1];
   end

`ifdef ISA_MON_FINISH_CYCLE_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         finish_cycle <= '0;
      else if (start)
         finish_cycle <= '0;
      else if (entering)
         finish_cycle <= cycles;
   end
`else
   assign finish_cycle = '0;
`endif

endmodule

// File: rtl/isa_result_monitor.sv
// rtl/isa_result_monitor.sv - multi-core tohost pass/fail/timeout monitor with shared cycle counter
// Optional: ISA_MON_FINISH_CYCLE_EN enables per-channel finish_cycle capture (port tied to 0 otherwise).
import isa_mon_pkg::*;

module isa_result_monitor #(
   parameter int          NUM_CH         = 1,
   parameter int          TIMEOUT_CYCLES = 10000,
   parameter logic [11:0] CSR_ADDR       = TOHOST_ADDR,
   localparam int         CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [NUM_CH-1:0]         csr_we,
   input  logic [12*NUM_CH-1:0]      csr_addr,
   input  logic [32*NUM_CH-1:0]      csr_wdata,
   output logic [STATUS_W*NUM_CH-1:0] status,
   output logic [CODE_W*NUM_CH-1:0]  fail_code,
   output logic                      done,
   output logic                      all_pass,
   output logic [CNT_W-1:0]          cycles,
   output logic [CNT_W*NUM_CH-1:0]   finish_cycle
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   status_e           st     [NUM_CH];
   status_e           st_nxt [NUM_CH];
   logic [NUM_CH-1:0] run_v;
   logic [NUM_CH-1:0] term_nxt;
   logic [NUM_CH-1:0] pass_nxt;
   logic              timeout_hit;

   assign timeout_hit = (cycles == LAST);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      isa_mon_channel #(
         .CSR_ADDR (CSR_ADDR),
         .CNT_W    (CNT_W)
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .start        (start),
         .timeout_hit  (timeout_hit),
         .csr_we       (csr_we[g]),
         .csr_addr     (csr_addr[12*g +: 12]),
         .csr_wdata    (csr_wdata[32*g +: 32]),
`ifdef ISA_MON_FINISH_CYCLE_EN
         .cycles       (cycles),
`endif
         .status       (st[g]),
         .status_nxt   (st_nxt[g]),
         .fail_code    (fail_code[CODE_W*g +: CODE_W]),
         .finish_cycle (finish_cycle[CNT_W*g +: CNT_W])
      );

      assign status[STATUS_W*g +: STATUS_W] = st[g];
      assign run_v[g]    = (st[g] == ST_RUN);
      assign term_nxt[g] = is_terminal(st_nxt[g]);
      assign pass_nxt[g] = (st_nxt[g] == ST_PASS);
   end

   // Saturation at LAST is safe: every RUN channel leaves RUN on that cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cycles <= '0;
      else if (start)
         cycles <= '0;
      else if ((|run_v) && (cycles != LAST))
         cycles <= cycles + CNT_W'(1);
   end

   // Registered from next-state so done/all_pass line up with the final status change.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done     <= 1'b0;
         all_pass <= 1'b0;
      end else begin
         done     <= &term_nxt;
         all_pass <= &pass_nxt;
      end
   end

endmodule

// File: tb/tb_isa_result_monitor.sv
// tb/tb_isa_result_monitor.sv - scoreboard bench for isa_result_monitor (3 channels, timeout 100)
module tb_isa_result_monitor;

   localparam int NCH = 3;
   localparam int T   = 100;
   localparam int CW  = $clog2(T + 1);

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic [NCH-1:0]     csr_we = '0;
   logic [12*NCH-1:0]  csr_addr = '0;
   logic [32*NCH-1:0]  csr_wdata = '0;
   logic [3*NCH-1:0]   status;
   logic [31*NCH-1:0]  fail_code;
   logic               done;
   logic               all_pass;
   logic [CW-1:0]      cycles;
   logic [CW*NCH-1:0]  finish_cycle;

   isa_result_monitor #(.NUM_CH(NCH), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .start(start),
      .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .status(status), .fail_code(fail_code), .done(done), .all_pass(all_pass),
      .cycles(cycles), .finish_cycle(finish_cycle)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3*NCH-1:0]  status;
      logic [31*NCH-1:0] fail_code;
      logic              done;
      logic              all_pass;
      logic [CW-1:0]     cycles;
      logic [CW*NCH-1:0] finish_cycle;
   } snap_t;

   snap_t exp_q[$];
   int checks = 0;
   int errors = 0;

   // Reference model state: plain integers per channel.
   localparam int S_IDLE = 0, S_RUN = 1, S_PASS = 2, S_FAIL = 3, S_TO = 4;
   int          m_st   [NCH];
   logic [30:0] m_code [NCH];
   int          m_fin  [NCH];
   int          m_cyc;
   bit          m_done, m_ap;

   bit          w_we   [NCH];
   logic [11:0] w_addr [NCH];
   logic [31:0] w_data [NCH];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit s);
      bit any_run;
      if (!r) begin
         for (int i = 0; i < NCH; i++) begin m_st[i] = S_IDLE; m_code[i] = '0; m_fin[i] = 0; end
         m_cyc = 0;
      end else if (s) begin
         for (int i = 0; i < NCH; i++) begin m_st[i] = S_RUN; m_code[i] = '0; m_fin[i] = 0; end
         m_cyc = 0;
      end else begin
         any_run = 0;
         for (int i = 0; i < NCH; i++) if (m_st[i] == S_RUN) any_run = 1;
         for (int i = 0; i < NCH; i++) begin
            if (m_st[i] == S_RUN) begin
               if (w_we[i] && w_addr[i] == 12'h51e && w_data[i][0]) begin
                  if ((w_data[i] >> 1) == 0) m_st[i] = S_PASS;
                  else begin m_st[i] = S_FAIL; m_code[i] = w_data[i][31:1]; end
                  m_fin[i] = m_cyc;
               end else if (m_cyc == T - 1) begin
                  m_st[i] = S_TO;
                  m_fin[i] = m_cyc;
               end
            end
         end
         if (any_run && m_cyc < T - 1) m_cyc++;
      end
      m_done = 1; m_ap = 1;
      for (int i = 0; i < NCH; i++) begin
         if (!(m_st[i] == S_PASS || m_st[i] == S_FAIL || m_st[i] == S_TO)) m_done = 0;
         if (m_st[i] != S_PASS) m_ap = 0;
      end
   endtask

   function automatic snap_t model_snap();
      snap_t e;
      e = '0;
      for (int i = 0; i < NCH; i++) begin
         e.status[3*i +: 3]     = 3'(m_st[i]);
         e.fail_code[31*i +: 31] = m_code[i];
`ifdef ISA_MON_FINISH_CYCLE_EN
         e.finish_cycle[CW*i +: CW] = CW'(m_fin[i]);
`endif
      end
      e.done = m_done;
      e.all_pass = m_ap;
      e.cycles = CW'(m_cyc);
      return e;
   endfunction

   task automatic clear_writes();
      for (int i = 0; i < NCH; i++) begin w_we[i] = 0; w_addr[i] = '0; w_data[i] = '0; end
   endtask

   // Drive one cycle of stimulus and queue the state expected after the next edge.
   task automatic step(input bit r, input bit s);
      @(negedge clk);
      rst = r;
      start = s;
      for (int i = 0; i < NCH; i++) begin
         csr_we[i] = w_we[i];
         csr_addr[12*i +: 12] = w_addr[i];
         csr_wdata[32*i +: 32] = w_data[i];
      end
      model_step(r, s);
      exp_q.push_back(model_snap());
      clear_writes();
   endtask

   task automatic put_write(input int ch, input logic [11:0] a, input logic [31:0] d);
      w_we[ch] = 1; w_addr[ch] = a; w_data[ch] = d;
   endtask

   // Monitor: compares every registered output one step after each driven cycle.
   initial begin
      snap_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("status",       128'(status),       128'(e.status));
            chk("fail_code",    128'(fail_code),    128'(e.fail_code));
            chk("done",         128'(done),         128'(e.done));
            chk("all_pass",     128'(all_pass),     128'(e.all_pass));
            chk("cycles",       128'(cycles),       128'(e.cycles));
            chk("finish_cycle", 128'(finish_cycle), 128'(e.finish_cycle));
         end
      end
   end

   initial begin
      clear_writes();
      model_step(0, 0);
      #1;
      chk("reset_status", 128'(status), 128'(0));
      chk("reset_cycles", 128'(cycles), 128'(0));
      chk("reset_done",   128'(done | all_pass), 128'(0));
      step(0, 0);
      step(1, 0);

      // Directed: pass at 10, fail code 5 at 20, ignored writes, late write on FAIL, pass on timeout cycle.
      step(1, 1);
      for (int n = 0; n < 110; n++) begin
         if (m_cyc == 10) put_write(0, 12'h51e, 32'h1);
         if (m_cyc == 20) put_write(1, 12'h51e, 32'hB);
         if (m_cyc == 30) put_write(2, 12'h51e, 32'h0);
         if (m_cyc == 31) put_write(2, 12'h51f, 32'h1);
         if (m_cyc == 40) put_write(1, 12'h51e, 32'h1);
         if (m_cyc == T - 1) put_write(2, 12'h51e, 32'h1);
         step(1, 0);
      end

      // Directed: silent run times out; cycles saturates.
      step(1, 1);
      for (int n = 0; n < 110; n++) step(1, 0);

      // Directed: start together with a valid write drops the write.
      put_write(0, 12'h51e, 32'h1);
      put_write(1, 12'h51e, 32'h7);
      step(1, 1);
      for (int n = 0; n < 5; n++) step(1, 0);

      // Directed: asynchronous reset mid-run.
      put_write(0, 12'h51e, 32'h7);
      step(1, 0);
      step(1, 0);
      step(0, 0);
      #1;
      chk("async_rst_status", 128'(status), 128'(0));
      chk("async_rst_cycles", 128'(cycles), 128'(0));
      chk("async_rst_code",   128'(fail_code), 128'(0));
      chk("async_rst_flags",  128'({done, all_pass}), 128'(0));
      chk("async_rst_fin",    128'(finish_cycle), 128'(0));
      step(1, 0);
      step(1, 0);

      // Randomized episodes with occasional restarts.
      for (int ep = 0; ep < 6; ep++) begin
         step(1, 1);
         for (int n = 0; n < 115; n++) begin
            for (int i = 0; i < NCH; i++) begin
               if ($urandom_range(0, 39) == 0) begin
                  w_we[i]   = ($urandom_range(0, 7) != 0);
                  w_addr[i] = ($urandom_range(0, 7) == 0) ? 12'h51f : 12'h51e;
                  w_data[i] = ($urandom_range(0, 2) == 0) ? 32'h1 : $urandom;
               end
            end
            step(1, ($urandom_range(0, 249) == 0));
         end
      end

      step(1, 0);
      @(posedge clk);
      #2;
      chk("queue_drained", 128'(exp_q.size()), 128'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
